phase_sequencer: RTL
====================

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter: CNT_W, default 32, width of the performance counters.
REQ-002 Parameter: MEM_TIMEOUT, default 16, maximum number of wait cycles on any memory handshake.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: run  input  1  level; execution permitted while high.
REQ-006 Port: halt_req  input  1  pulse; request to stop permanently after the current instruction.
REQ-007 Port: imem_ready  input  1  instruction memory has fetch data valid.
REQ-008 Port: mem_access  input  1  decoded instruction needs data memory; sampled in EXEC.
REQ-009 Port: dmem_ready  input  1  data memory access complete.
REQ-010 Port: phase  output  2  register-file phase: 00 fetch, 01 reg read, 10 execute/mem, 11 write back.
REQ-011 Port: ifetch_req  output  1  instruction fetch request.
REQ-012 Port: dmem_req  output  1  data memory request.
REQ-013 Port: wb_en  output  1  write-back permitted; high only in WB.
REQ-014 Port: stall  output  1  high in any cycle spent waiting on a ready input.
REQ-015 Port: halted  output  1  sticky; high in HALT.
REQ-016 Port: timeout_err  output  1  sticky; high in ERR.
REQ-017 Port: instr_count  output  CNT_W  number of completed WB cycles.
REQ-018 Port: stall_count  output  CNT_W  number of cycles with stall=1.

Function
REQ-019 The block SHALL implement a Moore FSM with states IDLE, FETCH, DECODE, EXEC, WB, HALT and ERR; all outputs SHALL be registered or decoded from state only.
REQ-020 phase SHALL be 00 in IDLE, FETCH, HALT and ERR; 01 in DECODE; 10 in EXEC; 11 in WB.
REQ-021 IDLE SHALL go to FETCH on the first edge with run=1, and otherwise remain in IDLE.
REQ-022 FETCH SHALL drive ifetch_req=1 and go to DECODE on the edge with imem_ready=1; otherwise it SHALL stay in FETCH with stall=1.
REQ-023 DECODE SHALL last exactly 1 cycle and then go to EXEC.
REQ-024 In EXEC with mem_access=0, the block SHALL spend 1 cycle and go to WB.
REQ-025 In EXEC with mem_access=1, the block SHALL drive dmem_req=1 and go to WB on the edge with dmem_ready=1; otherwise it SHALL stay in EXEC with stall=1.
REQ-026 When dmem_ready=1 in the first EXEC cycle, the block SHALL go to WB with zero stall cycles.
REQ-027 WB SHALL last exactly 1 cycle per instruction, because the register file advances the PC once per phase-11 cycle.
REQ-028 WB SHALL drive wb_en=1 and SHALL increment instr_count on leaving WB.
REQ-029 On leaving WB, the next state SHALL be: HALT if halt is pending; else IDLE if run=0; else FETCH.
REQ-030 A halt_req pulse in any state other than HALT or ERR SHALL set the pending-halt flag, which SHALL hold until HALT is entered.
REQ-031 halt_req in IDLE SHALL cause a transition to HALT on the next edge.
REQ-032 A wait counter SHALL clear on entry to FETCH or EXEC and increment on each stall cycle.
REQ-033 When the wait counter reaches MEM_TIMEOUT with ready still low, the next state SHALL be ERR.
REQ-034 HALT and ERR SHALL be absorbing; only reset leaves them; ifetch_req, dmem_req and wb_en SHALL be 0 in both.
REQ-035 instr_count and stall_count SHALL saturate at all-ones and not wrap.
REQ-036 Deasserting run mid-instruction SHALL NOT abort the instruction; it SHALL take effect only at WB exit.

Reset
REQ-037 While reset=1, asynchronously, the block SHALL set state=IDLE, phase=00, and all request/status outputs, both counters, the wait counter and the pending-halt flag to 0.
REQ-038 Reset asserted mid-handshake SHALL drop ifetch_req/dmem_req immediately, without waiting for a clock edge.

Verification
REQ-039 run=1, imem_ready=1, mem_access=0 -> repeating phase sequence 00,01,10,11 with period 4; instr_count=3 after 12 cycles; stall_count=0.
REQ-040 imem_ready low for 3 cycles, then mem_access=1 with dmem_ready low for 2 cycles -> FETCH lasts 4 cycles and EXEC 3 cycles; stall_count=5; wb_en high for exactly 1 cycle.
REQ-041 halt_req pulsed during DECODE -> the instruction completes WB, then halted=1, phase=00 and instr_count=1, all held for 20 further cycles.
REQ-042 MEM_TIMEOUT=16 and dmem_ready held 0 in EXEC -> ERR after 16 stall cycles, timeout_err=1, dmem_req=0; no WB occurs.
REQ-043 Reset asserted asynchronously between edges during EXEC with dmem_req=1 -> dmem_req and phase drop to 0 before the next edge; counters=0.
REQ-044 run dropped in EXEC -> WB still occurs, then IDLE; run reasserted -> FETCH on the next edge.

Source files
------------

// File: rtl/phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : phase_sequencer
// Description : Moore phase sequencer for a register-file datapath. It walks
//               FETCH/DECODE/EXEC/WB, waits on memory handshakes with a timeout,
//               and keeps saturating counters for instructions and stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_sequencer #(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             halt_req,
   input  logic             imem_ready,
   input  logic             mem_access,
   input  logic             dmem_ready,
   output logic [1:0]       phase,
   output logic             ifetch_req,
   output logic             dmem_req,
   output logic             wb_en,
   output logic             stall,
   output logic             halted,
   output logic             timeout_err,
   output logic [CNT_W-1:0] instr_count,
   output logic [CNT_W-1:0] stall_count
);

   localparam int                  c_wait_w    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]    c_cnt_max   = {CNT_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [c_wait_w-1:0] r_wait_cnt;
   logic                r_halt_pend;
   logic [CNT_W-1:0]    r_instr_cnt;
   logic [CNT_W-1:0]    r_stall_cnt;

   logic                w_stall;
   logic                w_timeout;
   logic                w_halt_any;

   // A handshake stalls only while its request is up and ready is still low.
   assign w_stall    = ((r_state == S_FETCH) && !imem_ready) ||
                       ((r_state == S_EXEC) && mem_access && !dmem_ready);
   // The last permitted stall cycle is the one seen with MEM_TIMEOUT-1 already counted.
   assign w_timeout  = w_stall && (r_wait_cnt == c_wait_last);
   assign w_halt_any = r_halt_pend || halt_req;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_halt_any) begin
               w_next = S_HALT;
            end else if (run) begin
               w_next = S_FETCH;
            end
         end
         S_FETCH: begin
            if (imem_ready) begin
               w_next = S_DECODE;
            end else if (w_timeout) begin
               w_next = S_ERR;
            end
         end
         S_DECODE: begin
            w_next = S_EXEC;
         end
         S_EXEC: begin
            if (!mem_access || dmem_ready) begin
               w_next = S_WB;
            end else if (w_timeout) begin
               w_next = S_ERR;
            end
         end
         S_WB: begin
            if (w_halt_any) begin
               w_next = S_HALT;
            end else if (!run) begin
               w_next = S_IDLE;
            end else begin
               w_next = S_FETCH;
            end
         end
         S_HALT:  w_next = S_HALT;
         S_ERR:   w_next = S_ERR;
         default: w_next = S_ERR;
      endcase
   end

   // Any state change restarts the wait count, which covers entry to FETCH and EXEC.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wait_cnt <= '0;
      end else if (r_state != w_next) begin
         r_wait_cnt <= '0;
      end else if (w_stall) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_halt_pend <= 1'b0;
      end else if (w_next == S_HALT) begin
         r_halt_pend <= 1'b0;
      end else if (halt_req && (r_state != S_ERR) && (r_state != S_HALT)) begin
         r_halt_pend <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_instr_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         if ((r_state == S_WB) && (r_instr_cnt != c_cnt_max)) begin
            r_instr_cnt <= r_instr_cnt + 1'b1;
         end
         if (w_stall && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      phase = 2'b00;
      case (r_state)
         S_DECODE: phase = 2'b01;
         S_EXEC:   phase = 2'b10;
         S_WB:     phase = 2'b11;
         default:  phase = 2'b00;
      endcase
   end

   assign ifetch_req  = (r_state == S_FETCH);
   assign dmem_req    = (r_state == S_EXEC) && mem_access;
   assign wb_en       = (r_state == S_WB);
   assign stall       = w_stall;
   assign halted      = (r_state == S_HALT);
   assign timeout_err = (r_state == S_ERR);
   assign instr_count = r_instr_cnt;
   assign stall_count = r_stall_cnt;

endmodule
`default_nettype wire
